spiker_result_writer: RTL and testbench

Parametrised successor to the single-frame spike result capture block. It captures a DATA_WIDTH-wide spike result vector on a sample strobe into a FRAME_DEPTH-deep frame FIFO. It then drains each frame as WIDTH-bit words through a valid/ready register-file write port. It reports frame completion, pending-frame count, and overflow (dropped frames). It sits between the spiker core output and the spiker_adapter register file.

---
 rtl/spiker_result_writer.sv | 188 ++++++++++++++++++
 tb/tb_spiker_result_writer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spiker_result_writer.sv
// spiker_result_writer: captures wide spike result vectors into a small
// frame FIFO and drains each frame as WIDTH-bit words over a valid/ready
// register-file write port. Reports completed frames, pending frames and
// dropped frames.
// Optional feature macro: SPIKER_RESULT_WRITER_POPCOUNT_EN appends a word
// at index N_WORDS carrying the number of set bits in the frame.
module spiker_result_writer #(
  parameter int WIDTH       = 32,
  parameter int DATA_WIDTH  = 800,
  parameter int FRAME_DEPTH = 2,
  parameter int CNT_W       = 16,
  localparam int N_WORDS    = (DATA_WIDTH + WIDTH - 1) / WIDTH,
  localparam int AW         = $clog2(N_WORDS + 1),
  localparam int PW         = $clog2(FRAME_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  input  logic                  sample_i,
  output logic                  wr_valid_o,
  input  logic                  wr_ready_i,
  output logic [AW-1:0]         wr_addr_o,
  output logic [WIDTH-1:0]      wr_data_o,
  output logic                  frame_done_o,
  output logic [PW-1:0]         pending_o,
  output logic                  overflow_o,
  output logic [CNT_W-1:0]      drop_count_o,
  output logic [CNT_W-1:0]      frame_count_o,
  input  logic                  clr_i
);

  localparam int PAD_W = N_WORDS * WIDTH;
  localparam int PTR_W = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;

`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2, COUNT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FRAME_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PW-1:0]         count;
  logic [WIDTH-1:0]      frame_q [N_WORDS];
  logic [PAD_W-1:0]      padded_head;
  logic [AW-1:0]         idx_q, idx_d;
  logic [WIDTH-1:0]      cur_word;
  logic                  pop, push, drop;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FRAME_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still accepts a sample when the head is leaving this cycle.
  assign push        = sample_i && ((count != PW'(FRAME_DEPTH)) || pop);
  assign drop        = sample_i && !push;
  assign padded_head = PAD_W'(fifo_mem[rd_ptr]);
  assign pending_o   = count;

  // FIFO storage; emptiness is carried by count, so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= data_out_i;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= inc_ptr(wr_ptr);
      if (pop)  rd_ptr <= inc_ptr(rd_ptr);
      if (push && !pop)      count <= count + PW'(1);
      else if (pop && !push) count <= count - PW'(1);
    end
  end

  // Frame register: a private copy of the head frame, split into words with
  // the top word zero-padded above DATA_WIDTH.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      for (int w = 0; w < N_WORDS; w++) frame_q[w] <= padded_head[w*WIDTH +: WIDTH];
    end
  end

  // Select the word addressed by the current index.
  always_comb begin
    cur_word = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      if (idx_q == AW'(w)) cur_word = frame_q[w];
    end
  end

`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
  logic [WIDTH-1:0] pop_cnt;

  // Spike count of the frame; padding bits are zero so they add nothing.
  always_comb begin
    pop_cnt = '0;
    for (int w = 0; w < N_WORDS; w++) begin
      for (int b = 0; b < WIDTH; b++) pop_cnt = pop_cnt + WIDTH'(frame_q[w][b]);
    end
  end
`endif

  // State register and word index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and write-port outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pop          = 1'b0;
    wr_valid_o   = 1'b0;
    wr_addr_o    = '0;
    wr_data_o    = '0;
    frame_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_valid_o = 1'b1;
        wr_addr_o  = idx_q;
        wr_data_o  = cur_word;
        if (wr_ready_i) begin
          idx_d = idx_q + AW'(1);
          if (idx_q == AW'(N_WORDS - 1)) begin
`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
            state_d = COUNT;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
      COUNT: begin
        wr_valid_o = 1'b1;
        wr_addr_o  = AW'(N_WORDS);
        wr_data_o  = pop_cnt;
        if (wr_ready_i) state_d = DONE;
      end
`endif
      DONE: begin
        frame_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completed-frame counter (wraps) and sticky drop reporting; a drop in the
  // same cycle as a clear restarts the count at one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_count_o <= '0;
      drop_count_o  <= '0;
      overflow_o    <= 1'b0;
    end else begin
      if (state_q == DONE) frame_count_o <= frame_count_o + CNT_W'(1);
      if (drop) begin
        overflow_o <= 1'b1;
        if (clr_i)                   drop_count_o <= CNT_W'(1);
        else if (drop_count_o != '1) drop_count_o <= drop_count_o + CNT_W'(1);
      end else if (clr_i) begin
        overflow_o   <= 1'b0;
        drop_count_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spiker_result_writer.sv
// Scoreboard bench for spiker_result_writer: stimulus pushes expected words,
// negedge monitors pop and compare on every accepted write.
// Honours SPIKER_RESULT_WRITER_POPCOUNT_EN for the trailing count word.
module tb_spiker_result_writer;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
  } exp2_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sample = 1'b0;
  logic         wr_ready = 1'b1;
  logic         clr = 1'b0;
  logic [799:0] data_out = '0;
  logic         wr_valid, frame_done, overflow;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;
  logic [1:0]   pending;
  logic [15:0]  drop_count, frame_count;

  logic         s_sample = 1'b0;
  logic         s_ready = 1'b1;
  logic [69:0]  s_data = '0;
  logic         s_valid, s_done, s_overflow;
  logic [1:0]   s_addr, s_pending;
  logic [31:0]  s_wdata;
  logic [15:0]  s_drop, s_fcount;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int done_seen2 = 0;
  int accepts = 0;

  exp_t  sb[$];
  exp2_t sb2[$];

  logic [31:0] pat[25];
  logic [31:0] ones[25];
  logic [31:0] c1[25];
  logic [31:0] c2[25];
  logic [31:0] c3[25];
  logic [31:0] c4[25];

  logic        stall_q = 1'b0;
  logic [4:0]  held_addr = '0;
  logic [31:0] held_data = '0;

  spiker_result_writer #(
    .WIDTH(32), .DATA_WIDTH(800), .FRAME_DEPTH(2), .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_out_i(data_out), .sample_i(sample),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .frame_done_o(frame_done), .pending_o(pending),
    .overflow_o(overflow), .drop_count_o(drop_count),
    .frame_count_o(frame_count), .clr_i(clr)
  );

  spiker_result_writer #(
    .WIDTH(32), .DATA_WIDTH(70), .FRAME_DEPTH(2), .CNT_W(16)
  ) dut_small (
    .clk_i(clk), .rst_i(rst), .data_out_i(s_data), .sample_i(s_sample),
    .wr_valid_o(s_valid), .wr_ready_i(s_ready), .wr_addr_o(s_addr),
    .wr_data_o(s_wdata), .frame_done_o(s_done), .pending_o(s_pending),
    .overflow_o(s_overflow), .drop_count_o(s_drop),
    .frame_count_o(s_fcount), .clr_i(1'b0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: presents one frame for one clock and records its
  // expected words if the model says it will be kept.
  task automatic applyStimulus(input logic [799:0] vec, input logic [31:0] expw[25],
                               input int popc, input bit kept);
    data_out = vec;
    sample   = 1'b1;
    if (kept) begin
      for (int w = 0; w < 25; w++) sb.push_back('{addr: 5'(w), data: expw[w]});
`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
      sb.push_back('{addr: 5'd25, data: 32'(popc)});
`endif
    end
    @(posedge clk);
    #1;
    sample = 1'b0;
  endtask

  task automatic waitDone(input int target, input int bound, input string name);
    int cyc;
    cyc = 0;
    while (done_seen < target && cyc < bound) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput(name, 64'(done_seen), 64'(target));
  endtask

  // Main-port monitor: hold stability during stalls and in-order word check.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!(wr_valid && wr_addr == held_addr && wr_data == held_data)) begin
          errors++;
          $display("[TB] FAIL stall_hold: got v=%0b a=%0d d=0x%0h, expected v=1 a=%0d d=0x%0h",
                   wr_valid, wr_addr, wr_data, held_addr, held_data);
        end
      end
      if (wr_valid && wr_ready) begin
        exp_t e;
        checks++;
        accepts++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_word: got a=%0d d=0x%0h, expected no word", wr_addr, wr_data);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("[TB] FAIL word: got a=%0d d=0x%0h, expected a=%0d d=0x%0h",
                     wr_addr, wr_data, e.addr, e.data);
          end
        end
      end
      stall_q   = wr_valid && !wr_ready;
      held_addr = wr_addr;
      held_data = wr_data;
      if (frame_done) done_seen++;
    end
  end

  // Narrow-instance monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_valid && s_ready) begin
        exp2_t e;
        checks++;
        if (sb2.size() == 0) begin
          errors++;
          $display("[TB] FAIL small_unexpected: got a=%0d d=0x%0h, expected no word", s_addr, s_wdata);
        end else begin
          e = sb2.pop_front();
          if (s_addr !== e.addr || s_wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL small_word: got a=%0d d=0x%0h, expected a=%0d d=0x%0h",
                     s_addr, s_wdata, e.addr, e.data);
          end
        end
      end
      if (s_done) done_seen2++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [799:0] vec;
    logic [3:0]   rdy_pat;
    int           acc0, cyc;
    bit           found;

    // Bit i set when i%3==0 gives a 96-bit period: three repeating words.
    for (int w = 0; w < 25; w++) begin
      case (w % 3)
        0:       pat[w] = 32'h49249249;
        1:       pat[w] = 32'h92492492;
        default: pat[w] = 32'h24924924;
      endcase
      ones[w] = 32'hFFFFFFFF;
      c1[w]   = 32'h11111111;
      c2[w]   = 32'h22222222;
      c3[w]   = 32'h33333333;
      c4[w]   = 32'h44444444;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_valid", 64'(wr_valid), 64'd0);
    checkOutput("rst_pending", 64'(pending), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_drop", 64'(drop_count), 64'd0);
    checkOutput("rst_fcount", 64'(frame_count), 64'd0);
    checkOutput("rst_done", 64'(frame_done), 64'd0);

    // Single frame with latency check
    $display("[TB] single frame");
    vec = '0;
    for (int i = 0; i < 800; i++) vec[i] = (i % 3 == 0);
    applyStimulus(vec, pat, 267, 1'b1);
    checkOutput("lat_not_yet", 64'(wr_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", 64'(wr_valid), 64'd1);
    checkOutput("lat_addr0", 64'(wr_addr), 64'd0);
    waitDone(1, 100, "single_done");
    checkOutput("single_fcount", 64'(frame_count), 64'd1);
    checkOutput("single_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure with ready pattern 1-0-0-1
    $display("[TB] backpressure");
    acc0    = accepts;
    rdy_pat = 4'b1001;
    applyStimulus(vec, pat, 267, 1'b1);
    cyc = 0;
    while (done_seen < 2 && cyc < 300) begin
      wr_ready = rdy_pat[cyc % 4];
      @(posedge clk);
      #1;
      cyc++;
    end
    wr_ready = 1'b1;
    checkOutput("bp_done", 64'(done_seen), 64'd2);
`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
    checkOutput("bp_accepts", 64'(accepts - acc0), 64'd26);
`else
    checkOutput("bp_accepts", 64'(accepts - acc0), 64'd25);
`endif
    checkOutput("bp_fcount", 64'(frame_count), 64'd2);

    // All-ones frame: trailing count word only with the feature
    $display("[TB] all-ones frame");
    applyStimulus('1, ones, 800, 1'b1);
    waitDone(3, 100, "ones_done");
    checkOutput("ones_sb_empty", 64'(sb.size()), 64'd0);

    // Overflow with four back-to-back samples and no ready
    $display("[TB] overflow");
    wr_ready = 1'b0;
    applyStimulus({25{32'h11111111}}, c1, 200, 1'b1);
    applyStimulus({25{32'h22222222}}, c2, 200, 1'b1);
    applyStimulus({25{32'h33333333}}, c3, 400, 1'b1);
    applyStimulus({25{32'h44444444}}, c4, 200, 1'b0);
    checkOutput("ovf_pending", 64'(pending), 64'd2);
    checkOutput("ovf_flag", 64'(overflow), 64'd1);
    checkOutput("ovf_drop", 64'(drop_count), 64'd1);
    checkOutput("ovf_valid", 64'(wr_valid), 64'd1);
    checkOutput("ovf_addr", 64'(wr_addr), 64'd0);
    clr = 1'b1;
    applyStimulus({25{32'h55555555}}, c4, 200, 1'b0);
    clr = 1'b0;
    checkOutput("clrdrop_flag", 64'(overflow), 64'd1);
    checkOutput("clrdrop_count", 64'(drop_count), 64'd1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checkOutput("clr_flag", 64'(overflow), 64'd0);
    checkOutput("clr_count", 64'(drop_count), 64'd0);
    checkOutput("clr_pending", 64'(pending), 64'd2);
    wr_ready = 1'b1;
    waitDone(6, 300, "ovf_drain_done");
    checkOutput("ovf_fcount", 64'(frame_count), 64'd6);
    checkOutput("ovf_pending_end", 64'(pending), 64'd0);
    checkOutput("ovf_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    applyStimulus(vec, pat, 267, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk);
      #1;
      if (wr_valid && wr_addr == 5'd10) found = 1'b1;
    end
    checkOutput("mid_reached_w10", 64'(found), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    checkOutput("mid_valid", 64'(wr_valid), 64'd0);
    checkOutput("mid_pending", 64'(pending), 64'd0);
    checkOutput("mid_fcount", 64'(frame_count), 64'd0);
    checkOutput("mid_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;
    done_seen = 0;
    applyStimulus(vec, pat, 267, 1'b1);
    waitDone(1, 100, "mid_restart_done");
    checkOutput("mid_restart_fcount", 64'(frame_count), 64'd1);
    checkOutput("mid_sb_empty", 64'(sb.size()), 64'd0);

    // Narrow instance: 70-bit all-ones vector, top word zero-padded
    $display("[TB] non-multiple width");
    sb2.push_back('{addr: 2'd0, data: 32'hFFFFFFFF});
    sb2.push_back('{addr: 2'd1, data: 32'hFFFFFFFF});
    sb2.push_back('{addr: 2'd2, data: 32'h0000003F});
`ifdef SPIKER_RESULT_WRITER_POPCOUNT_EN
    sb2.push_back('{addr: 2'd3, data: 32'd70});
`endif
    s_data   = '1;
    s_sample = 1'b1;
    @(posedge clk);
    #1;
    s_sample = 1'b0;
    cyc = 0;
    while (done_seen2 < 1 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("small_done", 64'(done_seen2), 64'd1);
    checkOutput("small_fcount", 64'(s_fcount), 64'd1);
    checkOutput("small_sb_empty", 64'(sb2.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
